// File: rtl/load_store_unit_pkg.sv
// Shared LSU definitions: RV32I func3 width codes, FSM state encoding, error causes.
// Pure constants, no logic.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MISAL   = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for stores, extraction/extension for loads, legality checks.
// Purely combinational (zero latency); no flow control.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_ex_off,
    input  logic [2:0]  i_ex_func3,
    input  logic        i_ex_is_store,
    input  logic [31:0] i_ex_rs2,
    input  logic [1:0]  i_ld_off,
    input  logic [2:0]  i_ld_func3,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misal,
    output logic        o_illegal
);

    logic [31:0] w_shift;

    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = 32'h0;
        case (i_ex_func3)
            F3_B: begin
                o_wstrb = 4'b0001 << i_ex_off;
                o_wdata = {4{i_ex_rs2[7:0]}};
            end
            F3_H: begin
                o_wstrb = 4'b0011 << i_ex_off;
                o_wdata = {2{i_ex_rs2[15:0]}};
            end
            F3_W: begin
                o_wstrb = 4'b1111;
                o_wdata = i_ex_rs2;
            end
            default: ;
        endcase
    end

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    always_comb begin
        if (i_ex_is_store)
            o_illegal = !(i_ex_func3 == F3_B || i_ex_func3 == F3_H || i_ex_func3 == F3_W);
        else
            o_illegal = !(i_ex_func3 == F3_B  || i_ex_func3 == F3_H || i_ex_func3 == F3_W ||
                          i_ex_func3 == F3_BU || i_ex_func3 == F3_HU);
        o_misal = ((i_ex_func3 == F3_H || i_ex_func3 == F3_HU) && i_ex_off[0]) ||
                  ((i_ex_func3 == F3_W) && (i_ex_off != 2'b00));
    end

    assign w_shift = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        case (i_ld_func3)
            F3_B:    o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_BU:   o_ldata = {24'h0, w_shift[7:0]};
            F3_HU:   o_ldata = {16'h0, w_shift[15:0]};
            default: o_ldata = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one aligned access per transaction over req/gnt/rvalid; bus held until gnt.
// Accept T -> mem_req T+1; store st_done T+2, load wb_valid one cycle after rvalid; ex_ready only in IDLE.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [2:0]      ex_func3,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic [4:0]      ex_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            st_done,
    output logic            lsu_err,
    output logic [1:0]      err_cause
);

    localparam int CW = 16;
    localparam logic [CW-1:0] C_TO_LAST = CW'(TIMEOUT_CYC - 1);

    logic [1:0]      r_state;
    logic            r_mem_req, r_mem_we, r_wb_valid, r_st_done, r_lsu_err;
    logic [XLEN-1:0] r_mem_addr, r_mem_wdata, r_wb_data;
    logic [3:0]      r_mem_wstrb;
    logic [4:0]      r_rd, r_wb_rd;
    logic [1:0]      r_err_cause, r_off;
    logic [2:0]      r_func3;
    logic [CW-1:0]   r_cnt;

    logic [3:0]      w_wstrb;
    logic [31:0]     w_wdata, w_ldata;
    logic            w_misal, w_illegal, w_one_op, w_timeout;

    lsu_align u_align (
        .i_ex_off      (ex_addr[1:0]),
        .i_ex_func3    (ex_func3),
        .i_ex_is_store (ex_is_store),
        .i_ex_rs2      (ex_wdata),
        .i_ld_off      (r_off),
        .i_ld_func3    (r_func3),
        .i_rdata       (mem_rdata),
        .o_wstrb       (w_wstrb),
        .o_wdata       (w_wdata),
        .o_ldata       (w_ldata),
        .o_misal       (w_misal),
        .o_illegal     (w_illegal)
    );

    assign w_one_op  = ex_is_load ^ ex_is_store;
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == C_TO_LAST);

    // A gnt/rvalid in the timeout cycle is checked first, so it wins over the error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= 4'b0000;
            r_mem_wdata <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= '0;
            r_st_done   <= 1'b0;
            r_lsu_err   <= 1'b0;
            r_err_cause <= ERR_NONE;
            r_cnt       <= '0;
            r_rd        <= 5'd0;
            r_off       <= 2'b00;
            r_func3     <= 3'b000;
        end else begin
            r_wb_valid <= 1'b0;
            r_st_done  <= 1'b0;
            r_lsu_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid && w_one_op) begin
                        if (w_illegal) begin
                            r_lsu_err   <= 1'b1;
                            r_err_cause <= ERR_ILLEGAL;
                        end else if (w_misal) begin
                            r_lsu_err   <= 1'b1;
                            r_err_cause <= ERR_MISAL;
                        end else begin
                            r_state     <= S_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= ex_is_store;
                            r_mem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
                            r_mem_wstrb <= ex_is_store ? w_wstrb : 4'b0000;
                            r_mem_wdata <= ex_is_store ? w_wdata : '0;
                            r_rd        <= ex_rd;
                            r_off       <= ex_addr[1:0];
                            r_func3     <= ex_func3;
                            r_cnt       <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        if (r_mem_we) begin
                            r_st_done <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state   <= S_WAIT;
                        end
                    end else if (w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_lsu_err   <= 1'b1;
                        r_err_cause <= ERR_TIMEOUT;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_ldata;
                        r_state    <= S_IDLE;
                    end else if (w_timeout) begin
                        r_lsu_err   <= 1'b1;
                        r_err_cause <= ERR_TIMEOUT;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ex_ready  = (r_state == S_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign st_done   = r_st_done;
    assign lsu_err   = r_lsu_err;
    assign err_cause = r_err_cause;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the ALU in the execute/memory stage of the RV32I core.
- Takes the ALU result as the effective address (rs1 + imm), plus rs2 store data and func3.
- Performs one aligned LB/LH/LW/LBU/LHU/SB/SH/SW per transaction over a req/gnt/rvalid data bus.
- Returns sign- or zero-extended load data to writeback.

Parameters:
XLEN, 32, datapath and address width; only 32 supported.
TIMEOUT_CYC, 255, max cycles waiting in REQ or WAIT before bus error; 0 disables timeout.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
ex_valid  input  1  execute stage presents a memory op
ex_ready  output  1  LSU can accept; high only in IDLE
ex_addr  input  32  effective address (ALU out)
ex_wdata  input  32  store data (rs2)
ex_func3  input  3  instr[14:12]: width/sign
ex_is_load  input  1  op is load
ex_is_store  input  1  op is store
ex_rd  input  5  load destination register
mem_req  output  1  bus request; held until mem_gnt
mem_we  output  1  1 = write
mem_addr  output  32  word address, {addr[31:2],2'b00}
mem_wstrb  output  4  byte enables (0 for loads)
mem_wdata  output  32  lane-replicated store data
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data word
wb_valid  output  1  one-cycle pulse: load result valid
wb_rd  output  5  load destination
wb_data  output  32  extended load data
st_done  output  1  one-cycle pulse: store granted
lsu_err  output  1  one-cycle pulse: misaligned/illegal func3 or timeout
err_cause  output  2  01 misaligned, 10 illegal func3, 11 timeout; valid with lsu_err

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; mem_req, mem_we, wb_valid, st_done, lsu_err = 0; mem_addr, mem_wstrb, mem_wdata, wb_rd, wb_data, err_cause = 0; timeout counter = 0.
- Reset mid-operation abandons any request. mem_req drops the cycle after reset. A late mem_rvalid for the abandoned load is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE: ex_ready = 1. Accept when ex_valid.
  - Exactly one of is_load/is_store set and the op is legal and aligned: latch op, drive bus registers, go to REQ.
  - Misaligned (H with addr[0] = 1, W with addr[1:0] != 0) or illegal func3: no bus access; next cycle lsu_err = 1 with cause; stay IDLE.
  - Legal func3: loads 000/001/010/100/101, stores 000/001/010.
  - Neither or both of is_load/is_store: accepted and dropped; no output.
- REQ: mem_req = 1; mem_we/addr/wstrb/wdata stable until mem_gnt.
  - On gnt, store: st_done pulse next cycle, go to IDLE.
  - On gnt, load: go to WAIT.
- WAIT: mem_rvalid is honoured only here; the bus never returns rvalid in the gnt cycle. On rvalid: next cycle wb_valid = 1, wb_rd, wb_data; go to IDLE.
- Timeout: counter clears on entering REQ or WAIT and increments each cycle in those states. When it reaches TIMEOUT_CYC, with TIMEOUT_CYC != 0:
  - lsu_err pulse, cause 11, go to IDLE, mem_req drops.
  - A gnt/rvalid arriving in the same cycle as the timeout wins; no error is raised.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111, wdata = rs2.
- Load extract: s = rdata >> (8*addr[1:0]). LB/LH sign-extend s[7:0]/s[15:0]; LBU/LHU zero-extend; LW passes rdata.
- Latency, gnt same cycle as mem_req: accept T, mem_req T+1. Load: rvalid earliest T+2, wb_valid T+3. Store: st_done T+2. Throughput: one op per transaction, no overlap.
- All outputs are registered; pulses are exactly one cycle.

Decomposition:
- Shared core package/header holds:
  - func3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - LSU state encoding (IDLE=0, REQ=1, WAIT=2).
  - err_cause codes.
- One natural combinational sub-module, lsu_align, provides:
  - store lane steering: wstrb and wdata from addr[1:0], func3, rs2.
  - load extraction: wb_data from rdata, addr[1:0], func3.
  - misaligned/illegal detection.
- The FSM, timeout counter and registers stay in load_store_unit.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt immediately -> mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, mem_we 1; st_done at T+2.
- SB addr 0x203, rs2 0x000000A5 -> mem_addr 0x200, wstrb 1000, wdata 0xA5A5A5A5.
- LB addr 0x301, rdata 0x1234_80FF, rvalid 2 cycles after gnt -> wb_data 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x302 -> 0x00001234.
- LW addr 0x102 -> lsu_err pulse, cause 01, mem_req never asserted; ex_ready stays 1. Load func3 011 -> cause 10.
- Load with gnt withheld, TIMEOUT_CYC = 4 -> lsu_err cause 11 after 4 REQ cycles, mem_req drops; a following SW completes normally.
- rst_n low while in WAIT, then rvalid arrives in IDLE -> no wb_valid; all outputs at reset values the cycle after reset.
